// File: rtl/cla_pkg.sv
// Shared constants and flag layout for the two-stage carry-lookahead adder pipeline.
package cla_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int TAG_W_DEF = 4;
    localparam int GRP_W     = 4;

    localparam int FLAG_W = 3;
    localparam int COUT   = 0;
    localparam int OVF    = 1;
    localparam int ZERO   = 2;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic cout, input logic ovf, input logic zero);
        flags_t f;
        f       = '0;
        f[COUT] = cout;
        f[OVF]  = ovf;
        f[ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational N-bit carry-lookahead adder: 4-bit group generate/propagate with
// every group and bit carry expanded as a flat sum of products (no ripple between groups).
module cla_block
    import cla_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    localparam int NG = N / GRP_W;

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [N:0]    c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : group_gp
        logic term;
        term = 1'b0;
        gg   = '0;
        gp   = '0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[j*GRP_W +: GRP_W];
            for (int i = 0; i < GRP_W; i++) begin
                term = g[j*GRP_W + i];
                for (int k = i + 1; k < GRP_W; k++) begin
                    term = term & p[j*GRP_W + k];
                end
                gg[j] = gg[j] | term;
            end
        end
    end

    // Group carry j = OR_k (G[k] & P[k+1..j-1]) | (P[0..j-1] & cin)
    always_comb begin : group_carry
        logic term;
        logic carry;
        term  = 1'b0;
        carry = 1'b0;
        gc    = '0;
        gc[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            carry = cin;
            for (int m = 0; m < j; m++) begin
                carry = carry & gp[m];
            end
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                carry = carry | term;
            end
            gc[j] = carry;
        end
    end

    always_comb begin : bit_carry
        logic term;
        logic carry;
        term  = 1'b0;
        carry = 1'b0;
        c     = '0;
        for (int j = 0; j < NG; j++) begin
            c[j*GRP_W] = gc[j];
            for (int i = 1; i < GRP_W; i++) begin
                carry = gc[j];
                for (int m = 0; m < i; m++) begin
                    carry = carry & p[j*GRP_W + m];
                end
                for (int k = 0; k < i; k++) begin
                    term = g[j*GRP_W + k];
                    for (int m = k + 1; m < i; m++) begin
                        term = term & p[j*GRP_W + m];
                    end
                    carry = carry | term;
                end
                c[j*GRP_W + i] = carry;
            end
        end
        c[N] = gc[NG];
    end

    assign sum   = p ^ c[N-1:0];
    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/cla_pipe.sv
// Two-stage pipelined add/subtract with valid/ready handshake: S1 adds the low half,
// S2 adds the high half using the registered low carry and registers sum, flags and tag.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [H-1:0]     lo_sum;
    logic             lo_cout;
    logic             lo_cmsb_unused;

    logic             v1;
    logic [H-1:0]     s1_lo;
    logic             s1_c;
    logic [H-1:0]     s1_ahi;
    logic [H-1:0]     s1_bhi;
    logic [TAG_W-1:0] s1_tag;

    logic [H-1:0]     hi_sum;
    logic             hi_cout;
    logic             hi_cmsb;
    logic [WIDTH-1:0] full_sum;

    logic             v2;
    logic [WIDTH-1:0] s2_sum;
    flags_t           s2_flags;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_load;
    logic             accept;
    logic             s1_adv;

    // Subtraction is a + ~b + 1, so the caller's carry-in is overridden.
    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub ? 1'b1 : in_cin;

    assign s2_load  = !v2 || out_ready;
    assign in_ready = !v1 || s2_load;
    assign accept   = in_valid && in_ready;
    assign s1_adv   = v1 && s2_load;

    cla_block #(.N(H)) u_lo (
        .a     (in_a[H-1:0]),
        .b     (b_eff[H-1:0]),
        .cin   (c0),
        .sum   (lo_sum),
        .cout  (lo_cout),
        .c_msb (lo_cmsb_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else begin
            v1 <= accept || (v1 && !s2_load);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lo  <= '0;
            s1_c   <= 1'b0;
            s1_ahi <= '0;
            s1_bhi <= '0;
            s1_tag <= '0;
        end else if (accept) begin
            s1_lo  <= lo_sum;
            s1_c   <= lo_cout;
            s1_ahi <= in_a[WIDTH-1:H];
            s1_bhi <= b_eff[WIDTH-1:H];
            s1_tag <= in_tag;
        end
    end

    cla_block #(.N(H)) u_hi (
        .a     (s1_ahi),
        .b     (s1_bhi),
        .cin   (s1_c),
        .sum   (hi_sum),
        .cout  (hi_cout),
        .c_msb (hi_cmsb)
    );

    assign full_sum = {hi_sum, s1_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (s2_load) begin
            v2 <= v1;
        end
    end

    // Loading only on a real advance keeps a stalled result intact when S1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
        end else if (s1_adv) begin
            s2_sum   <= full_sum;
            s2_flags <= pack_flags(hi_cout, hi_cmsb ^ hi_cout, full_sum == '0);
            s2_tag   <= s1_tag;
        end
    end

    assign out_valid = v2;
    assign out_sum   = s2_sum;
    assign out_cout  = s2_flags[COUT];
    assign out_ovf   = s2_flags[OVF];
    assign out_zero  = s2_flags[ZERO];
    assign out_tag   = s2_tag;

endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 8 in the range 8..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each transaction.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  block accepts the offer this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 in_cin  input  1  carry-in; ignored when in_sub=1.
REQ-009 in_sub  input  1  1 selects subtraction a-b, 0 selects addition a+b+cin.
REQ-010 in_tag  input  TAG_W  opaque tag returned with the result.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum  output  WIDTH  result.
REQ-014 out_cout, out_ovf, out_zero  output  1 each  carry-out, signed overflow, zero flag.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 Effective operands SHALL be: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
REQ-017 A transfer SHALL occur on an edge where in_valid&in_ready=1 (input side) or out_valid&out_ready=1 (output side).
REQ-018 Stage S1 SHALL register four things on acceptance: the low half sum (a[H-1:0]+b_eff[H-1:0]+c0, with H=WIDTH/2), that addition's carry-out, the upper operand halves, and the tag.
REQ-019 Stage S2 SHALL compute the upper half using the registered S1 carry as carry-in, then register the full sum, the flags and the tag.
REQ-020 Latency SHALL be exactly 2 cycles: accepted at edge k, out_valid=1 after edge k+1 when no stall.
REQ-021 S2 SHALL load when !v2 || out_ready; S1 SHALL advance into S2 exactly when S2 loads.
REQ-022 in_ready SHALL equal !v1 || s2_load; sustained throughput SHALL be one operation per cycle; a combinational path out_ready->in_ready is permitted.
REQ-023 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-024 Data registers SHALL load only on stage advance; a bubble SHALL NOT overwrite a held result.
REQ-025 out_cout SHALL be the carry out of bit WIDTH-1; for subtraction it SHALL be 1 when there is no borrow.
REQ-026 out_ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-027 out_zero SHALL be 1 iff out_sum==0.
REQ-028 Results SHALL leave in acceptance order; no loss, duplication or reordering.
REQ-029 Simultaneous output drain and input accept with both stages full SHALL shift the pipeline without a bubble.

Reset
REQ-030 rst_n=0 SHALL immediately clear v1 and v2, force out_valid=0, and set out_sum, flags and out_tag to 0.
REQ-031 Reset mid-operation SHALL discard in-flight transactions; after release no stale result SHALL appear.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Package cla_pkg SHALL hold the default WIDTH and TAG_W constants and the flag-bit index constants (COUT, OVF, ZERO).
REQ-034 Sub-module cla_block #(N) SHALL be a purely combinational N-bit carry-lookahead adder built from 4-bit group generate/propagate.
REQ-035 cla_block SHALL output sum, carry-out and carry-into-MSB, and SHALL be instantiated twice with N=WIDTH/2.
REQ-036 The design SHALL be ripple-free across groups and SHALL contain no latches.

Verification
REQ-037 WIDTH=16, a=0x7FFF, b=0x0001, add, cin=0 -> sum 0x8000, ovf=1, cout=0, zero=0, out_valid two edges after accept.
REQ-038 a=0x0005, b=0x0005, sub -> sum 0x0000, zero=1, cout=1, ovf=0; a=0x0003, b=0x0005, sub -> sum 0xFFFE, cout=0.
REQ-039 Cross-half carry: a=0x00FF, b=0x0001 -> 0x0100; a=0xFFFF, b=0x0000, cin=1 -> 0x0000, cout=1, zero=1.
REQ-040 Tags 1,2,3 sent back-to-back with out_ready=0 for 3 cycles -> in_ready=0 once two are held, outputs stable, then results delivered in tag order 1,2,3.
REQ-041 rst_n pulsed low with both stages full -> out_valid=0 asynchronously, in_ready=1 after release, no stale result emitted.
REQ-042 10k random operations with random in_valid/out_ready, WIDTH=16 and WIDTH=32, SHALL match a behavioural model bit-exactly (sum and flags).
